stream_rr_arbiter: RTL and testbench

- Shares one valid/ready output stream between NUM_IN valid/ready requesters using round-robin arbitration.
- Two-entry output buffer (main + skid) sustains 1 transfer/cycle.
- No combinational path from out_ready to any in_ready.
- Sits between several producer units and a single consumer unit in the datapath. Honours the consumer's enable_transfer gating, same semantics as the unit-level skid handshake.

---
 rtl/stream_rr_arbiter_pkg.sv | 18 +
 rtl/stream_rr_arbiter_rr_priority_pick.sv | 31 +++
 rtl/stream_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_stream_rr_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stream_rr_arbiter_pkg.sv
// Shared definitions for the round-robin stream arbiter: buffer state encoding
// and the constant log2 helper used to size source indices.
package stream_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_priority_pick
  import stream_rr_arbiter_pkg::*;
#(
  parameter int NUM_IN = 4,
  localparam int SRC_W = clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SRC_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [SRC_W-1:0]  winner,
  output logic              any
);

  always_comb begin
    int idx;
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = (int'(ptr) + k) % NUM_IN;
      if (!any && req[idx]) begin
        any        = 1'b1;
        winner     = SRC_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of NUM_IN valid/ready streams into one output stream with a
// two-entry (main + skid) buffer, so in_ready never depends on out_ready.
module stream_rr_arbiter
  import stream_rr_arbiter_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 32,
  localparam int SRC_W = clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        grant,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     enable_transfer,
  output logic [DATA_W-1:0]        out_data,
  output logic [SRC_W-1:0]         out_source,
  output logic                     out_transfer
);

  arb_state_e        state_q, state_d;
  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [SRC_W-1:0]  main_src_q, main_src_d, skid_src_q, skid_src_d;

  logic [NUM_IN-1:0] pick_grant;
  logic [SRC_W-1:0]  pick_winner;
  logic              pick_any;
  logic [DATA_W-1:0] new_data;
  logic              in_xfer;
  logic              out_xfer;

  rr_priority_pick #(.NUM_IN(NUM_IN)) u_pick (
    .req    (in_valid),
    .ptr    (ptr_q),
    .grant  (pick_grant),
    .winner (pick_winner),
    .any    (pick_any)
  );

  // Acceptance is allowed only in states with a free slot; the illegal
  // encoding also refuses input so nothing is accepted while recovering.
  assign grant        = rst ? '0 : pick_grant;
  assign in_ready     = (rst || !(state_q == ST_EMPTY || state_q == ST_ONE)) ? '0 : pick_grant;
  assign out_valid    = !rst && (state_q == ST_ONE || state_q == ST_FULL);
  assign out_transfer = out_valid && out_ready && enable_transfer;
  assign out_data     = main_data_q;
  assign out_source   = main_src_q;

  assign new_data = in_data[int'(pick_winner)*DATA_W +: DATA_W];
  assign in_xfer  = pick_any && |(in_valid & in_ready);
  assign out_xfer = out_transfer;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    main_data_d = main_data_q;
    main_src_d  = main_src_q;
    skid_data_d = skid_data_q;
    skid_src_d  = skid_src_q;

    if (in_xfer) begin
      ptr_d = (pick_winner == SRC_W'(NUM_IN - 1)) ? '0 : pick_winner + SRC_W'(1);
    end

    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d     = ST_ONE;
          main_data_d = new_data;
          main_src_d  = pick_winner;
        end
      end
      ST_ONE: begin
        case ({in_xfer, out_xfer})
          2'b11: begin
            main_data_d = new_data;
            main_src_d  = pick_winner;
          end
          2'b10: begin
            state_d     = ST_FULL;
            skid_data_d = new_data;
            skid_src_d  = pick_winner;
          end
          2'b01:   state_d = ST_EMPTY;
          default: state_d = ST_ONE;
        endcase
      end
      ST_FULL: begin
        if (out_xfer) begin
          state_d     = ST_ONE;
          main_data_d = skid_data_q;
          main_src_d  = skid_src_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      ptr_q       <= '0;
      main_data_q <= '0;
      main_src_q  <= '0;
      skid_data_q <= '0;
      skid_src_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      main_data_q <= main_data_d;
      main_src_q  <= main_src_d;
      skid_data_q <= skid_data_d;
      skid_src_q  <= skid_src_d;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed scenarios plus random traffic, checked
// against an occupancy/pointer reference model and an ordered expected queue.
module tb_stream_rr_arbiter;

  localparam int NUM_IN = 4;
  localparam int DATA_W = 32;
  localparam int SRC_W  = 2;
  localparam int EXP_W  = SRC_W + DATA_W;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_IN-1:0]        in_valid = '0;
  logic [NUM_IN-1:0]        in_ready;
  logic [NUM_IN*DATA_W-1:0] in_data = '0;
  logic [NUM_IN-1:0]        grant;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic                     enable_transfer = 1'b0;
  logic [DATA_W-1:0]        out_data;
  logic [SRC_W-1:0]         out_source;
  logic                     out_transfer;

  stream_rr_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .grant           (grant),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .enable_transfer (enable_transfer),
    .out_data        (out_data),
    .out_source      (out_source),
    .out_transfer    (out_transfer)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] word [NUM_IN];
  int tests  = 0;
  int fails  = 0;
  int m_ptr  = 0;
  int m_cnt  = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // Reference model: rotating priority from the last winner, two-slot buffer
  // occupancy count, and an ordered list of accepted words.
  always @(negedge clk) begin
    int w;
    bit any, ixf, oxf;
    logic [NUM_IN-1:0] eg;
    if (rst) begin
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      m_ptr = 0;
      m_cnt = 0;
      exp_q.delete();
    end else begin
      any = 1'b0;
      w   = 0;
      for (int k = 0; k < NUM_IN; k++) begin
        if (!any && in_valid[(m_ptr + k) % NUM_IN]) begin
          any = 1'b1;
          w   = (m_ptr + k) % NUM_IN;
        end
      end
      eg = any ? NUM_IN'(1 << w) : '0;
      chk("grant", 64'(grant), 64'(eg));
      chk("in_ready", 64'(in_ready), (m_cnt < 2) ? 64'(eg) : 64'd0);
      chk("out_valid", 64'(out_valid), 64'(m_cnt > 0));
      oxf = (m_cnt > 0) && out_ready && enable_transfer;
      chk("out_transfer", 64'(out_transfer), 64'(oxf));
      ixf = any && (m_cnt < 2);
      if (ixf) begin
        exp_q.push_back({w[SRC_W-1:0], in_data[w*DATA_W +: DATA_W]});
        m_ptr = (w + 1) % NUM_IN;
      end
      m_cnt = m_cnt + int'(ixf) - int'(oxf);
    end
  end

  // Monitor: head word must match the oldest accepted word; pop on transfer.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", 64'd1, 64'd0);
      end else begin
        chk("out_data", 64'(out_data), 64'(exp_q[0][DATA_W-1:0]));
        chk("out_source", 64'(out_source), 64'(exp_q[0][EXP_W-1:DATA_W]));
        if (out_transfer) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rand_words();
    for (int i = 0; i < NUM_IN; i++) word[i] = $urandom;
  endtask

  task automatic step(input logic [NUM_IN-1:0] v, input logic ordy, input logic en);
    in_valid        = v;
    out_ready       = ordy;
    enable_transfer = en;
    for (int i = 0; i < NUM_IN; i++) in_data[i*DATA_W +: DATA_W] = word[i];
    @(posedge clk);
    #1;
  endtask

  initial begin
    rand_words();
    rst = 1'b1;
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b1);
    rst = 1'b0;

    // Full contention: sources rotate 0,1,2,3,0...
    for (int i = 0; i < NUM_IN; i++) word[i] = 32'h100 + i;
    repeat (8) step(4'b1111, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);

    // Backpressure on a single requester, then drain in order.
    word[2] = 32'hA;
    step(4'b0100, 1'b0, 1'b1);
    word[2] = 32'hB;
    step(4'b0100, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b1);
    repeat (3) step(4'b0000, 1'b1, 1'b1);

    // Wrap-around: bring the pointer to 3, then requesters 1 and 3 compete.
    rand_words();
    step(4'b0100, 1'b1, 1'b1);
    rand_words();
    step(4'b1010, 1'b1, 1'b1);
    rand_words();
    step(4'b1010, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);

    // enable_transfer gating fills the buffer despite out_ready.
    rand_words();
    step(4'b0001, 1'b1, 1'b0);
    rand_words();
    step(4'b0010, 1'b1, 1'b0);
    rand_words();
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    repeat (3) step(4'b0000, 1'b1, 1'b1);

    // Single requester streaming.
    for (int n = 0; n < 8; n++) begin
      rand_words();
      step(4'b0001, 1'b1, 1'b1);
    end
    step(4'b0000, 1'b1, 1'b1);

    // Reset while full.
    repeat (3) begin
      rand_words();
      step(4'b1111, 1'b0, 1'b1);
    end
    rst = 1'b1;
    step(4'b1111, 1'b0, 1'b1);
    rst = 1'b0;
    rand_words();
    step(4'b0001, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rand_words();
      rst = ($urandom_range(0, 199) == 0);
      step(NUM_IN'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) != 0);
    end
    rst = 1'b0;
    repeat (6) step(4'b0000, 1'b1, 1'b1);

    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
